// File: rtl/reg_file_clr.sv
// ============================================================================
// Module      : reg_file_clr
// Description : DEPTH x W register file, one write port, two registered read
//               ports with write bypass, optional zero register 0, and a
//               sequenced bulk-clear engine with busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_clr #(
  parameter int W        = 8,
  parameter int AW       = 4,
  parameter int ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done
);

  localparam int            c_DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] c_CNT_LAST = AW'(c_DEPTH - 1);
  localparam logic          c_ZERO_REG = (ZERO_REG != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic          r_clr_done;
  logic [W-1:0]  r_mem [c_DEPTH];
  logic [W-1:0]  r_rdata_a;
  logic [W-1:0]  r_rdata_b;

  logic          w_wen;
  logic [AW-1:0] w_waddr;
  logic [W-1:0]  w_wdata;

  // The clear engine owns the write port while busy; external writes are dropped.
  always_comb begin
    w_wen   = 1'b0;
    w_waddr = waddr;
    w_wdata = wdata;
    if (r_busy) begin
      w_wen   = 1'b1;
      w_waddr = r_cnt;
      w_wdata = '0;
    end else begin
      w_wen   = we;
    end
    if (c_ZERO_REG && (w_waddr == '0)) begin
      w_wen = 1'b0;
    end
  end

  function automatic logic [W-1:0] read_sel(input logic [AW-1:0] addr);
    logic [W-1:0] v;
    if (c_ZERO_REG && (addr == '0)) begin
      v = '0;
    end else if (w_wen && (w_waddr == addr)) begin
      v = w_wdata;
    end else begin
      v = r_mem[addr];
    end
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wen) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      r_rdata_a <= read_sel(raddr_a);
      r_rdata_b <= read_sel(raddr_b);
    end
  end

  // busy/clr_done are loaded together with the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_cnt == c_CNT_LAST) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_clr_done <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;
  assign busy     = r_busy;
  assign clr_done = r_clr_done;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_clr.sv
// ============================================================================
// Module      : tb_reg_file_clr
// Description : Directed self-checking bench for reg_file_clr (plain and
//               zero-register instances driven from shared stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_clr;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic          clr_req;
  logic [W-1:0]  rdata_a,   rdata_b;
  logic          busy,      clr_done;
  logic [W-1:0]  rdata_a_z, rdata_b_z;
  logic          busy_z,    clr_done_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file_clr #(.W(W), .AW(AW), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  reg_file_clr #(.W(W), .AW(AW), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a_z), .rdata_b(rdata_b_z),
    .clr_req(clr_req), .busy(busy_z), .clr_done(clr_done_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, leaving time 1 unit past it for sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) wr(AW'(i), W'(8'h80 + i));
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
    repeat (2) step();
    chk("reset_rdata_a", rdata_a, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", clr_done, 0);
    rst = 1'b0;
    step();

    // basic write/read
    wr(4'd3, 8'hA5);
    raddr_a = 4'd3; raddr_b = 4'd3;
    step();
    chk("rw_a", rdata_a, 8'hA5);
    chk("rw_b", rdata_b, 8'hA5);

    // asynchronous reset mid-cycle, no edge
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", rdata_a, 0);
    chk("async_rst_b", rdata_b, 0);
    rst = 1'b0;
    step();
    step();
    chk("rst_cleared_mem3", rdata_a, 0);

    // bypass
    wr(4'd5, 8'h11);
    we = 1'b1; waddr = 4'd5; wdata = 8'h3C; raddr_a = 4'd5; raddr_b = 4'd5;
    step();
    we = 1'b0;
    chk("bypass_a", rdata_a, 8'h3C);
    chk("bypass_b", rdata_b, 8'h3C);

    // register 0: ordinary vs hardwired zero
    we = 1'b1; waddr = 4'd0; wdata = 8'hFF; raddr_a = 4'd0; raddr_b = 4'd0;
    step();
    we = 1'b0;
    chk("r0_bypass_plain", rdata_a, 8'hFF);
    chk("r0_bypass_zero", rdata_a_z, 8'h00);
    step();
    chk("r0_read_plain", rdata_b, 8'hFF);
    chk("r0_read_zero", rdata_b_z, 8'h00);

    // bulk clear with port A watching addr 15
    fill();
    raddr_a = 4'd15; raddr_b = 4'd15;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = busy ? 1 : 0;
    chk("clr_start_busy", busy, 1);
    chk("clr_start_rd15", rdata_a, 8'h8F);
    for (int k = 1; k <= 16; k++) begin
      if (k == 11) begin
        we = 1'b1; waddr = 4'd7; wdata = 8'h55;
      end
      step();
      we = 1'b0;
      if (busy) busy_cnt++;
      chk($sformatf("clr_rd15_k%0d", k), rdata_a, (k < 16) ? 8'h8F : 8'h00);
      if (k < 16) chk($sformatf("clr_done_low_k%0d", k), clr_done, 0);
    end
    chk("clr_busy_cycles", busy_cnt, 16);
    chk("clr_done_pulse", clr_done, 1);
    chk("clr_busy_end", busy, 0);
    step();
    chk("clr_done_single", clr_done, 0);
    for (int i = 0; i < 16; i++) begin
      raddr_a = AW'(i); raddr_b = AW'(15 - i);
      step();
      chk($sformatf("clr_zero_a%0d", i), rdata_a, 0);
      chk($sformatf("clr_zero_b%0d", 15 - i), rdata_b, 0);
    end

    // reset in the middle of a clear
    fill();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (6) step();
    chk("mid_clr_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", clr_done, 0);
    #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      raddr_a = AW'(k); raddr_b = 4'd12;
      step();
      chk($sformatf("mid_rst_zero%0d", k), rdata_a, 0);
      chk($sformatf("mid_rst_nodone%0d", k), clr_done, 0);
    end
    wr(4'd9, 8'h42);
    raddr_a = 4'd9;
    step();
    chk("post_rst_rw", rdata_a, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
